fft_frame_feeder: RTL

//   Conditions raw ADC samples and delivers them to the FFT core as framed AXI-Stream data.

---
 rtl/fft_frame_feeder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ADC decimator, midscale removal and framed AXI-Stream feeder for the FFT
module fft_frame_feeder #(
  parameter int AD_W       = 10,
  parameter int DECIM      = 8,
  parameter int FRAME_LEN  = 4096,
  parameter int FIFO_DEPTH = 16,
  parameter int CONTINUOUS = 0
) (
  input  logic            fft_clk,
  input  logic            rst,
  input  logic [AD_W-1:0] ad_data,
  input  logic            ad_valid,
  input  logic            start,
  output logic [15:0]     m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            m_tlast,
  output logic            busy,
  output logic            frame_done,
  output logic            overflow
);

  localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 0;
  localparam int ACC_W = AD_W + DW;
  localparam int PH_W  = (DECIM > 1) ? DW : 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  // Offset-binary midscale summed over one decimation group
  localparam logic [15:0] MID = 16'((1 << (AD_W - 1)) * DECIM);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [15:0]        res_q, res_d;
  logic               res_vld_q, res_vld_d;
  logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [16:0]        mem_q [FIFO_DEPTH];

  logic [ACC_W-1:0]   acc_sum;
  logic               grp_done;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push_try;
  logic               push;
  logic               drop;
  logic               push_last;
  logic               arm;
  logic [16:0]        head;

  // Next-state computation for FSM, decimator, push counter and FIFO pointers
  always_comb begin
    acc_sum    = acc_q + ACC_W'(ad_data);
    grp_done   = (phase_q == PH_W'(DECIM - 1));
    fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    head       = mem_q[rd_ptr_q];
    pop        = !fifo_empty && m_tready;
    // Results only enter the FIFO while capturing; a pop on the same cycle frees a slot
    push_try   = res_vld_q && (state_q == S_CAPTURE);
    push       = push_try && (!fifo_full || pop);
    drop       = push_try && !push;
    push_last  = (push_cnt_q == CNT_W'(FRAME_LEN - 1));
    arm        = ((state_q == S_IDLE) && start) ||
                 ((state_q == S_DONE) && (CONTINUOUS != 0));

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (push && push_last) state_d = S_FLUSH;
      S_FLUSH:   if (pop && head[16]) state_d = S_DONE;
      S_DONE:    state_d = (CONTINUOUS != 0) ? S_CAPTURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    acc_d     = acc_q;
    phase_d   = phase_q;
    res_vld_d = 1'b0;
    res_d     = res_q;
    if (arm) begin
      acc_d   = '0;
      phase_d = '0;
    end else if ((state_q == S_CAPTURE) && ad_valid) begin
      if (grp_done) begin
        acc_d     = '0;
        phase_d   = '0;
        res_vld_d = 1'b1;
        res_d     = 16'(acc_sum) - MID;
      end else begin
        acc_d   = acc_sum;
        phase_d = phase_q + PH_W'(1);
      end
    end

    push_cnt_d = push_cnt_q;
    if (arm) push_cnt_d = '0;
    else if (push) push_cnt_d = push_cnt_q + CNT_W'(1);

    overflow_d = overflow_q;
    if ((state_q == S_IDLE) && start) overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    busy_d       = (state_d == S_CAPTURE) || (state_d == S_FLUSH);
    frame_done_d = (state_d == S_DONE);
  end

  // State registers with synchronous reset; a reset abandons any frame in flight
  always_ff @(posedge fft_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      phase_q      <= '0;
      res_q        <= '0;
      res_vld_q    <= 1'b0;
      push_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      res_q        <= res_d;
      res_vld_q    <= res_vld_d;
      push_cnt_q   <= push_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage: each entry carries the sample and its end-of-frame tag
  always_ff @(posedge fft_clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, res_q};
  end

  assign m_tvalid   = !fifo_empty;
  assign m_tdata    = fifo_empty ? 16'h0000 : head[15:0];
  assign m_tlast    = !fifo_empty && head[16];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
